// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory store buffer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   word_t        32-bit data word
//   idx_t         word index extracted from a 32-bit byte address (bits [31:2])
//   sb_entry_t    store-buffer entry {idx, data}
//   SB_PTR_W      pointer width for the default store-buffer depth
//   sb_ptr_w()    pointer width for an arbitrary power-of-2 depth
//   word_idx()    byte address -> word index, wrapped to 2**addr_w words
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 30;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Index is kept zero-extended to IDX_W bits so every entry compares with
  // the same width regardless of ADDR_W; bits above ADDR_W are always zero.
  typedef struct packed {
    idx_t  idx;
    word_t data;
  } sb_entry_t;

  localparam int SB_DEPTH_DEFAULT = 4;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int SB_PTR_W = sb_ptr_w(SB_DEPTH_DEFAULT);

  // Drop the byte offset and wrap the word index modulo 2**addr_w.
  function automatic idx_t word_idx(input logic [31:0] adr, input int addr_w);
    idx_t mask;
    mask = (idx_t'(1) << addr_w) - idx_t'(1);
    return adr[31:2] & mask;
  endfunction

endpackage

// File: rtl/dmem_sb_fifo.sv
// dmem_sb_fifo: circular store-buffer FIFO with an associative lookup port.
// Latency: push/pop take effect at the next posedge; lookup is combinational.
// Backpressure: push is ignored while full, pop ignored while empty; the
//   caller is expected to gate push with full.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   push, push_ent  enqueue push_ent at the tail
//   pop             drop the head entry
//   lookup_idx      word index compared against every occupied entry
//   head_ent        oldest entry (valid when !empty)
//   count           occupied entries (0..DEPTH)
//   full, empty     occupancy flags
//   hit, hit_data   some occupied entry matches lookup_idx; data of youngest match
module dmem_sb_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  sb_entry_t                push_ent,
  input  logic                     pop,
  input  idx_t                     lookup_idx,
  output sb_entry_t                head_ent,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     hit,
  output word_t                    hit_data
);

  localparam int PTR_W = sb_ptr_w(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the slot bits are equal.
  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  sb_entry_t        mem [DEPTH];

  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] match_vec;
  logic [PTR_W-1:0] age;
  logic [PTR_W-1:0] slot;

  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (head[PTR_W] != tail[PTR_W]) &&
                    (head[PTR_W-1:0] == tail[PTR_W-1:0]);
  assign head_ent = mem[head[PTR_W-1:0]];

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
    end
  end

  // Storage needs no reset: occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[tail[PTR_W-1:0]] <= push_ent;
  end

  // A slot is occupied when its distance from the head is below count.
  always_comb begin
    occ       = '0;
    match_vec = '0;
    age       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age          = PTR_W'(i) - head[PTR_W-1:0];
      occ[i]       = ({1'b0, age} < count);
      match_vec[i] = occ[i] && (mem[i].idx == lookup_idx);
    end
  end

  // Walk slots oldest to youngest; the last match seen is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head[PTR_W-1:0] + PTR_W'(k);
      if (match_vec[slot]) begin
        hit      = 1'b1;
        hit_data = mem[slot].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: MEM-stage data memory with a FIFO store buffer in front of a word RAM.
// Latency: loads 0 cycles (combinational); stores reach the RAM >=1 cycle after acceptance.
// Backpressure: stall (combinational) holds the MEM-stage request while high.
//
// Optional feature macro: STORE_FWD_EN
//   defined   : loads hitting buffered stores are forwarded (youngest wins), no stall
//   undefined : loads hitting buffered stores stall until the buffer drains past them
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; empties the buffer, RAM is kept
//   memwrite   store request
//   memread    load request
//   dataadr    byte address; word index = dataadr[ADDR_W+1:2]
//   writedata  store data
//   readdata   load data (combinational)
//   stall      hold the current MEM-stage request
//   sb_count   occupied store-buffer entries
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memwrite,
  input  logic                        memread,
  input  logic [31:0]                 dataadr,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        stall,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int RAM_WORDS = 1 << ADDR_W;

  word_t      ram [RAM_WORDS];

  idx_t       req_idx;
  word_t      ram_rd;
  sb_entry_t  push_ent;
  sb_entry_t  head_ent;
  logic       sb_full;
  logic       sb_empty;
  logic       sb_hit;
  word_t      sb_hit_data;
  logic       accept;
  logic       drain;
  logic       unused_idx_hi;

  assign req_idx  = word_idx(dataadr, ADDR_W);
  assign ram_rd   = ram[req_idx[ADDR_W-1:0]];
  assign push_ent = '{idx: req_idx, data: writedata};

  // Stall sources. A store is refused only when the buffer is full; without
  // forwarding a load must also wait for any older store to the same word.
`ifdef STORE_FWD_EN
  assign stall    = memwrite & sb_full;
  assign readdata = (memread && sb_hit) ? sb_hit_data : ram_rd;
`else
  assign stall    = (memwrite & sb_full) | (memread & sb_hit);
  assign readdata = ram_rd;
`endif

  assign accept = memwrite & ~stall;

  // The RAM port is free whenever no load uses it this cycle; during a stall
  // the pipeline's load is being held anyway, so draining then is what lets
  // a full buffer or a load/store conflict make progress. Nothing drains in
  // a reset cycle so that discarded stores never reach the RAM.
  assign drain  = ~sb_empty & (~memread | stall) & ~reset;

  dmem_sb_fifo #(
    .DEPTH (SB_DEPTH)
  ) u_sb_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_ent   (push_ent),
    .pop        (drain),
    .lookup_idx (req_idx),
    .head_ent   (head_ent),
    .count      (sb_count),
    .full       (sb_full),
    .empty      (sb_empty),
    .hit        (sb_hit),
    .hit_data   (sb_hit_data)
  );

  always_ff @(posedge clk) begin
    if (drain) ram[head_ent.idx[ADDR_W-1:0]] <= head_ent.data;
  end

  // Index bits above ADDR_W are always zero after wrapping.
  assign unused_idx_hi = ^head_ent.idx[IDX_W-1:ADDR_W];

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam int ADDR_W   = 8;
  localparam int SB_DEPTH = 4;
  localparam int NW       = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic [$clog2(SB_DEPTH):0] sb_count;

  always #5 clk = ~clk;

  dmem_store_buffer #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .sb_count  (sb_count)
  );

  // Reference model: pending stores as an ordered list, memory as an array.
  typedef struct { int idx; logic [31:0] data; } ent_t;
  ent_t        sbq[$];
  logic [31:0] ram_m [NW];
  bit          known [NW];
  bit          rst_seen = 0;

  typedef struct {
    bit          chk;
    bit          chk_rd;
    bit          stall;
    logic [31:0] rd;
    int          cnt;
    int          cyc;
  } exp_t;
  exp_t expq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual %h required %h", nm, c, act, req);
    end
  endtask

  // One pipeline cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit rst, input bit we, input bit re,
                      input logic [31:0] adr, input logic [31:0] wd, output bit st);
    exp_t        e;
    int          idx;
    bit          hit;
    logic [31:0] yd;
    bit          full;
    @(negedge clk);
    reset = rst; memwrite = we; memread = re; dataadr = adr; writedata = wd;
    idx  = int'(adr[31:2]) % NW;
    hit  = 0;
    yd   = '0;
    foreach (sbq[i]) if (sbq[i].idx == idx) begin hit = 1; yd = sbq[i].data; end
    full = (sbq.size() == SB_DEPTH);
`ifdef STORE_FWD_EN
    e.stall  = we && full;
    e.rd     = (re && hit) ? yd : ram_m[idx];
    e.chk_rd = (re && hit) || known[idx];
`else
    e.stall  = (we && full) || (re && hit);
    e.rd     = ram_m[idx];
    e.chk_rd = known[idx];
`endif
    e.chk = rst_seen;
    e.cnt = sbq.size();
    e.cyc = cyc;
    expq.push_back(e);
    st = e.stall;
    if (rst) begin
      sbq.delete();
      rst_seen = 1;
    end else begin
      if (sbq.size() > 0 && (!re || e.stall)) begin
        ram_m[sbq[0].idx] = sbq[0].data;
        known[sbq[0].idx] = 1;
        void'(sbq.pop_front());
      end
      if (we && !e.stall) sbq.push_back('{idx, wd});
    end
    cyc++;
  endtask

  // Pipeline behaviour: hold the request while stalled (bounded).
  task automatic req(input bit we, input bit re, input logic [31:0] adr, input logic [31:0] wd);
    bit st;
    int tries;
    tries = 0;
    do begin
      step(1'b0, we, re, adr, wd, st);
      tries++;
    end while (st && tries < 16);
    if (st) begin
      n_chk++;
      n_fail++;
      $display("FAIL stall_bound cycle %0d: actual stalled %0d cycles required < 16", cyc, tries);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: compares DUT outputs late in each cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.chk) begin
          check("stall", e.cyc, {31'b0, stall}, {31'b0, e.stall});
          check("sb_count", e.cyc, 32'(sb_count), e.cnt);
          if (e.chk_rd) check("readdata", e.cyc, readdata, e.rd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    logic [31:0] a;
    reset = 1'b1; memwrite = 1'b0; memread = 1'b0; dataadr = '0; writedata = '0;

    // Reset for two cycles, then idle: empty buffer, no stall.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, st);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, st);
    idle(1);

    // Give every RAM word a known value.
    for (int i = 0; i < NW; i++) req(1'b1, 1'b0, 32'(i * 4), $urandom);
    idle(6);

    // Store then immediate load of the same word.
    req(1'b1, 1'b0, 32'd84, 32'd7);
    req(1'b0, 1'b1, 32'd84, 32'h0);
    req(1'b0, 1'b1, 32'd84, 32'h0);
    idle(4);

    // Fill with memread held high, then a fifth store against a full buffer.
    for (int k = 0; k < 4; k++) req(1'b1, 1'b1, 32'(160 + 4 * k), 32'(100 + k));
    req(1'b1, 1'b1, 32'd200, 32'd104);
    idle(6);

    // Same word twice: youngest data wins.
    req(1'b1, 1'b0, 32'd80, 32'd1);
    req(1'b1, 1'b0, 32'd80, 32'd2);
    req(1'b0, 1'b1, 32'd80, 32'h0);
    idle(4);
    req(1'b0, 1'b1, 32'd80, 32'h0);

    // Address wrap: 0x400 is word 0 with ADDR_W=8.
    req(1'b1, 1'b0, 32'h400, 32'hCAFE_F00D);
    req(1'b0, 1'b1, 32'h0, 32'h0);
    idle(4);
    req(1'b0, 1'b1, 32'h0, 32'h0);

    // Three pending stores discarded by reset.
    for (int k = 0; k < 3; k++) req(1'b1, 1'b1, 32'(40 + 4 * k), 32'hDEAD_0000 + k);
    step(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, st);
    idle(1);
    for (int k = 0; k < 3; k++) req(1'b0, 1'b1, 32'(40 + 4 * k), 32'h0);

    // Steady enqueue and drain with a constant occupancy of two.
    req(1'b1, 1'b1, 32'd500, 32'h11);
    req(1'b1, 1'b1, 32'd504, 32'h22);
    for (int k = 0; k < 10; k++) req(1'b1, 1'b0, 32'(600 + 4 * k), 32'(1000 + k));
    idle(6);
    for (int k = 0; k < 10; k++) req(1'b0, 1'b1, 32'(600 + 4 * k), 32'h0);

    // Random traffic over a small index set with random high/offset bits.
    for (int n = 0; n < 1500; n++) begin
      a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'h0,
           8'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 99) == 0) begin
        step(1'b1, 1'($urandom), 1'($urandom), a, $urandom, st);
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: req(1'b1, 1'b0, a, $urandom);
          4, 5, 6:    req(1'b0, 1'b1, a, 32'h0);
          7:          req(1'b1, 1'b1, a, $urandom);
          default:    idle(1);
        endcase
      end
    end
    idle(8);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", cyc, 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
